// File: rtl/memory_arbiter_pkg.sv
// Shared CPU types for the memory arbiter: FSM states, grant owner and access kind.
// Also holds the byte-enable helper used when an access is latched.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2,
    DONE   = 2'd3
  } arbStateType;

  typedef enum logic {
    GR_I = 1'b0,
    GR_D = 1'b1
  } grantType;

  typedef enum logic {
    CU_RD = 1'b0,
    CU_WR = 1'b1
  } cuOPType;

  localparam logic [3:0] BE_ALL = 4'hF;

  // Reads always fetch the full word; only writes honour the caller's byte enables.
  function automatic logic [3:0] strobe_be(input cuOPType op, input logic [3:0] be);
    return (op == CU_WR) ? be : BE_ALL;
  endfunction

endpackage

// File: rtl/memory_arbiter_wait.sv
// Wait counter for the RAM access window: counts while enabled and flags the
// final cycle (count == LATENCY-1), wrapping back to zero on that edge.
module wait_counter #(
  parameter int LATENCY = 2
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign done = (count_q == CW'(LATENCY - 1));

  always_comb begin
    count_d = count_q;
    if (clear || (enable && done)) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises instruction fetches and data loads/stores onto one fixed-latency
// single-port RAM; data accesses win over fetches when both are pending.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 10
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemRen,
  input  logic [31:0]       imemaddr,
  input  logic              dmmRen,
  input  logic              dmmWen,
  input  logic [31:0]       dmmaddr,
  input  logic [31:0]       dmmstore,
  input  logic [3:0]        dmmbe,
  output logic              i_ready,
  output logic              d_ready,
  output logic [31:0]       imemload,
  output logic [31:0]       dmmload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [31:0]       ram_rdata
);

  arbStateType       state_q;
  grantType          grant_q;
  cuOPType           op_q;
  logic              ren_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [31:0]       iload_q;
  logic [31:0]       dload_q;

  logic busy;
  logic cnt_done;

  assign busy = (state_q == D_BUSY) || (state_q == I_BUSY);

  wait_counter #(
    .LATENCY(LATENCY)
  ) u_wait (
    .CLK   (CLK),
    .nRST  (nRST),
    .clear (!busy),
    .enable(busy),
    .done  (cnt_done)
  );

  // Byte-offset and high address bits never reach the word-addressed RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imemaddr[31:ADDR_W+2], imemaddr[1:0],
                              dmmaddr[31:ADDR_W+2], dmmaddr[1:0]};

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= IDLE;
      grant_q <= GR_I;
      op_q    <= CU_RD;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dmmWen || dmmRen) begin
            // A simultaneous read+write request is treated as a write only.
            state_q <= D_BUSY;
            grant_q <= GR_D;
            op_q    <= dmmWen ? CU_WR : CU_RD;
            ren_q   <= !dmmWen;
            wen_q   <= dmmWen;
            addr_q  <= dmmaddr[ADDR_W+1:2];
            wdata_q <= dmmstore;
            be_q    <= strobe_be(dmmWen ? CU_WR : CU_RD, dmmbe);
          end else if (imemRen) begin
            state_q <= I_BUSY;
            grant_q <= GR_I;
            op_q    <= CU_RD;
            ren_q   <= 1'b1;
            wen_q   <= 1'b0;
            addr_q  <= imemaddr[ADDR_W+1:2];
            wdata_q <= '0;
            be_q    <= BE_ALL;
          end
        end
        D_BUSY, I_BUSY: begin
          if (cnt_done) begin
            if (op_q == CU_RD) begin
              if (grant_q == GR_D) begin
                dload_q <= ram_rdata;
              end else begin
                iload_q <= ram_rdata;
              end
            end
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        // One dead cycle lets request_unit drop the completed request.
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign i_ready   = (state_q == DONE) && (grant_q == GR_I);
  assign d_ready   = (state_q == DONE) && (grant_q == GR_D);
  assign imemload  = iload_q;
  assign dmmload   = dload_q;
  assign ram_ren   = ren_q;
  assign ram_wen   = wen_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_be    = be_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a transaction-timeline model checked every
// cycle, plus hand-computed expectations from the access scenarios.
module tb_memory_arbiter;

  localparam int LAT = 2;
  localparam int AW  = 10;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          imemRen;
  logic [31:0]   imemaddr;
  logic          dmmRen;
  logic          dmmWen;
  logic [31:0]   dmmaddr;
  logic [31:0]   dmmstore;
  logic [3:0]    dmmbe;
  logic          i_ready;
  logic          d_ready;
  logic [31:0]   imemload;
  logic [31:0]   dmmload;
  logic          ram_ren;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_be;
  logic [31:0]   ram_rdata;

  memory_arbiter #(.LATENCY(LAT), .ADDR_W(AW)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemRen(imemRen), .imemaddr(imemaddr),
    .dmmRen(dmmRen), .dmmWen(dmmWen), .dmmaddr(dmmaddr),
    .dmmstore(dmmstore), .dmmbe(dmmbe),
    .i_ready(i_ready), .d_ready(d_ready),
    .imemload(imemload), .dmmload(dmmload),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata)
  );

  initial forever #5 CLK = ~CLK;

  int          n_total = 0;
  int          n_pass  = 0;
  int          cyc     = 0;
  bit          started = 0;
  logic [31:0] rd_word = 32'h0;
  int          hcnt    = 0;
  int          nacc    = 0;
  bit          prev_s  = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, got, want);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // RAM: read data is only valid in the last cycle of the strobe window.
  initial begin
    ram_rdata = 32'hBAD0BAD0;
    forever begin
      @(posedge CLK);
      #1;
      if (ram_ren === 1'b1) hcnt++;
      else hcnt = 0;
      ram_rdata = (ram_ren === 1'b1 && hcnt == LAT) ? rd_word : 32'hBAD0BAD0;
    end
  end

  always @(negedge CLK) begin
    if ((ram_ren === 1'b1 || ram_wen === 1'b1) && !prev_s) nacc++;
    prev_s = (ram_ren === 1'b1 || ram_wen === 1'b1);
  end

  // Model: a transaction accepted in cycle s strobes in s+1..s+LAT,
  // pulses ready in s+LAT+1, and the next one may be accepted from s+LAT+2.
  bit          m_act = 0;
  int          m_s   = 0;
  bit          m_d, m_wr;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wdata, m_word;
  logic [3:0]  m_be;
  logic [31:0] m_iload = 32'h0;
  logic [31:0] m_dload = 32'h0;
  bit          e_ren, e_wen, e_ir, e_dr;

  always @(negedge CLK) begin
    if (started) begin
      e_ren = 0; e_wen = 0; e_ir = 0; e_dr = 0;
      if (m_act && cyc > m_s && cyc <= m_s + LAT) begin
        e_ren = !m_wr;
        e_wen = m_wr;
      end
      if (m_act && cyc == m_s + LAT + 1) begin
        if (m_d) e_dr = 1; else e_ir = 1;
        if (!m_wr) begin
          if (m_d) m_dload = m_word; else m_iload = m_word;
        end
      end
      check("m_ram_ren", 32'(ram_ren), 32'(e_ren));
      check("m_ram_wen", 32'(ram_wen), 32'(e_wen));
      check("m_i_ready", 32'(i_ready), 32'(e_ir));
      check("m_d_ready", 32'(d_ready), 32'(e_dr));
      check("m_imemload", imemload, m_iload);
      check("m_dmmload", dmmload, m_dload);
      if (e_ren || e_wen) begin
        check("m_ram_addr", 32'(ram_addr), 32'(m_addr));
        check("m_ram_be", 32'(ram_be), 32'(m_be));
      end
      if (e_wen) check("m_ram_wdata", ram_wdata, m_wdata);
      if (nRST) begin
        m_act = 0; m_iload = 32'h0; m_dload = 32'h0;
      end else if (m_act && cyc == m_s + LAT + 1) begin
        m_act = 0;
      end else if (!m_act && (dmmRen || dmmWen || imemRen)) begin
        m_act  = 1;
        m_s    = cyc;
        m_d    = dmmRen || dmmWen;
        m_wr   = dmmWen;
        m_addr = m_d ? dmmaddr[AW+1:2] : imemaddr[AW+1:2];
        m_wdata = dmmstore;
        m_be   = dmmWen ? dmmbe : 4'hF;
        m_word = rd_word;
      end
    end
  end

  task automatic wait_rdy(input bit want_d, output int n);
    n = 0;
    while (((want_d ? d_ready : i_ready) !== 1'b1) && n < 12) begin
      tick();
      n++;
    end
    check(want_d ? "d_ready_seen" : "i_ready_seen", 32'(want_d ? d_ready : i_ready), 32'd1);
  endtask

  int n;
  int acc0;

  initial begin
    nRST = 1; imemRen = 1; imemaddr = 32'h12341234;
    dmmRen = 0; dmmWen = 0; dmmaddr = 0; dmmstore = 0; dmmbe = 0;
    rd_word = 32'hCAFEF00D;
    tick();
    started = 1;
    check("rst_ram_ren", 32'(ram_ren), 32'd0);
    check("rst_i_ready", 32'(i_ready), 32'd0);
    check("rst_imemload", imemload, 32'h0);
    tick();
    check("rst2_ram_ren", 32'(ram_ren), 32'd0);
    nRST = 0;

    // Fetch
    tick();
    check("f_ram_ren", 32'(ram_ren), 32'd1);
    check("f_addr1", 32'(ram_addr), 32'h08D);
    tick();
    check("f_addr2", 32'(ram_addr), 32'h08D);
    tick();
    check("f_i_ready", 32'(i_ready), 32'd1);
    check("f_imemload", imemload, 32'hCAFEF00D);
    tick();
    imemRen = 0;

    // Data read
    dmmRen = 1; dmmaddr = 32'h00010001; rd_word = 32'hABCDABCD;
    tick();
    check("r_addr", 32'(ram_addr), 32'h000);
    check("r_be", 32'(ram_be), 32'hF);
    check("r_ren", 32'(ram_ren), 32'd1);
    wait_rdy(1, n);
    check("r_latency", n, LAT);
    check("r_dmmload", dmmload, 32'hABCDABCD);
    check("r_imemload", imemload, 32'hCAFEF00D);
    tick();
    dmmRen = 0;
    check("r_d_ready_off", 32'(d_ready), 32'd0);

    // Write
    dmmWen = 1; dmmaddr = 32'h01010101; dmmstore = 32'hDACBDACB; dmmbe = 4'b0011;
    tick();
    check("w_wen", 32'(ram_wen), 32'd1);
    check("w_ren", 32'(ram_ren), 32'd0);
    check("w_addr", 32'(ram_addr), 32'h040);
    check("w_wdata", ram_wdata, 32'hDACBDACB);
    check("w_be", 32'(ram_be), 32'h3);
    tick();
    check("w_wen2", 32'(ram_wen), 32'd1);
    wait_rdy(1, n);
    check("w_dmmload", dmmload, 32'hABCDABCD);
    tick();
    dmmWen = 0;

    // Contention: data first, then fetch
    acc0 = nacc;
    imemRen = 1; imemaddr = 32'h00000040; dmmRen = 1; dmmaddr = 32'h00000080;
    rd_word = 32'h11112222;
    tick();
    check("c_addr_data", 32'(ram_addr), 32'h020);
    wait_rdy(1, n);
    check("c_dmmload", dmmload, 32'h11112222);
    check("c_no_i_ready", 32'(i_ready), 32'd0);
    rd_word = 32'h33334444;
    tick();
    dmmRen = 0;
    wait_rdy(0, n);
    check("c_fetch_latency", n, LAT + 1);
    check("c_imemload", imemload, 32'h33334444);
    tick();
    imemRen = 0;
    tick();
    check("c_access_count", nacc - acc0, 2);

    // Fetch dropped while busy still completes
    imemRen = 1; imemaddr = 32'h00000008; rd_word = 32'h5A5A0001;
    tick();
    imemRen = 0;
    wait_rdy(0, n);
    check("drop_imemload", imemload, 32'h5A5A0001);
    tick();

    // Abort mid-access
    dmmRen = 1; dmmaddr = 32'h00000100; rd_word = 32'h77778888;
    tick();
    check("a_ren_busy", 32'(ram_ren), 32'd1);
    nRST = 1; dmmRen = 0;
    tick();
    check("a_ren_off", 32'(ram_ren), 32'd0);
    check("a_d_ready", 32'(d_ready), 32'd0);
    check("a_dmmload", dmmload, 32'h0);
    nRST = 0;
    tick();
    tick();
    check("a_no_late_ready", 32'(d_ready), 32'd0);

    // Read and write together: write only
    dmmRen = 1; dmmWen = 1; dmmaddr = 32'h0000000C; dmmstore = 32'h55AA55AA; dmmbe = 4'b1100;
    tick();
    check("rw_wen", 32'(ram_wen), 32'd1);
    check("rw_ren", 32'(ram_ren), 32'd0);
    check("rw_addr", 32'(ram_addr), 32'h003);
    check("rw_be", 32'(ram_be), 32'hC);
    wait_rdy(1, n);
    check("rw_dmmload", dmmload, 32'h0);
    tick();
    dmmRen = 0; dmmWen = 0;
    tick();
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
